array8_arbiter: RTL and testbench

//  Two-port round-robin arbiter and sequencer in front of the 8x8 register array.

---
 rtl/array8_arbiter_if.sv | 48 ++++
 rtl/array8_arbiter.sv | 110 +++++++++++
 tb/tb_array8_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/array8_arbiter_if.sv
// Bundle of requester A/B handshakes and the array port shared by the arbiter.
interface array8_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 3
);
    logic              a_req;
    logic              a_we;
    logic [IDX_W-1:0]  a_idx;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [IDX_W-1:0]  b_idx;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ready;
    logic              arr_en;
    logic              arr_wr_en;
    logic [IDX_W-1:0]  arr_wr_idx;
    logic [DATA_W-1:0] arr_wr_data;
    logic              arr_rd_en;
    logic [IDX_W-1:0]  arr_rd_idx;
    logic [DATA_W-1:0] arr_rd_data;

    modport slave (
        input  a_req, a_we, a_idx, a_wdata,
        input  b_req, b_we, b_idx, b_wdata,
        input  arr_rd_data,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ready, arr_en, arr_wr_en, arr_wr_idx, arr_wr_data, arr_rd_en, arr_rd_idx
    );

    modport master (
        output a_req, a_we, a_idx, a_wdata,
        output b_req, b_we, b_idx, b_wdata,
        output arr_rd_data,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ready, arr_en, arr_wr_en, arr_wr_idx, arr_wr_data, arr_rd_en, arr_rd_idx
    );
endinterface

// File: rtl/array8_arbiter.sv
// Round-robin arbiter sharing the 8x8 register array port between requesters A and B.
// Pulses the array init enable once after reset, then serves one access per cycle.
module array8_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    array8_arbiter_if.slave  bus
);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              rr_last;      // 1: B won the last grant
    logic              rr_last_nxt;
    logic              pend_a;
    logic              pend_b;
    logic              win_a;
    logic              win_b;
    logic              run;
    logic              init_en;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;

    // Outputs are held at zero while reset is asserted, even if state still reads RUN.
    assign run = (state == S_RUN) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_INIT;
            rr_last <= 1'b1;
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_last <= rr_last_nxt;
            pend_a  <= win_a && !bus.a_we;
            pend_b  <= win_b && !bus.b_we;
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_last_nxt = rr_last;
        init_en     = 1'b0;
        win_a       = 1'b0;
        win_b       = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_data     = '0;
        rd_en       = 1'b0;
        rd_idx      = '0;
        case (state)
            S_INIT: begin
                init_en   = !reset;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (run) begin
                    if (bus.a_req && bus.b_req) begin
                        win_a = rr_last;
                        win_b = !rr_last;
                    end else begin
                        win_a = bus.a_req;
                        win_b = bus.b_req;
                    end
                end
                if (win_a || win_b) begin
                    rr_last_nxt = win_b;
                end
                // Route the winner's access onto the single array port.
                if (win_a) begin
                    wr_en   = bus.a_we;
                    wr_idx  = bus.a_we ? bus.a_idx : '0;
                    wr_data = bus.a_we ? bus.a_wdata : '0;
                    rd_en   = !bus.a_we;
                    rd_idx  = bus.a_we ? '0 : bus.a_idx;
                end else if (win_b) begin
                    wr_en   = bus.b_we;
                    wr_idx  = bus.b_we ? bus.b_idx : '0;
                    wr_data = bus.b_we ? bus.b_wdata : '0;
                    rd_en   = !bus.b_we;
                    rd_idx  = bus.b_we ? '0 : bus.b_idx;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    assign bus.ready       = run;
    assign bus.arr_en      = init_en;
    assign bus.a_gnt       = win_a;
    assign bus.b_gnt       = win_b;
    assign bus.arr_wr_en   = wr_en;
    assign bus.arr_wr_idx  = wr_idx;
    assign bus.arr_wr_data = wr_data;
    assign bus.arr_rd_en   = rd_en;
    assign bus.arr_rd_idx  = rd_idx;

    // Read data arrives from the array one cycle after the grant.
    assign bus.a_rvalid = pend_a && !reset;
    assign bus.b_rvalid = pend_b && !reset;
    assign bus.a_rdata  = bus.a_rvalid ? bus.arr_rd_data : DATA_W'(0);
    assign bus.b_rdata  = bus.b_rvalid ? bus.arr_rd_data : DATA_W'(0);
endmodule

// File: tb/tb_array8_arbiter.sv
// Directed bench for array8_arbiter with a behavioural 8x8 register array behind it.
module tb_array8_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    array8_arbiter_if #(.DATA_W(8), .IDX_W(3)) bus ();

    array8_arbiter #(.DATA_W(8), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: constant image loaded by arr_en, registered read port.
    logic [7:0] mem [8];
    logic [7:0] image [8];
    logic [7:0] rd_q;

    initial begin
        image[0] = 8'd236; image[1] = 8'd175; image[2] = 8'h11; image[3] = 8'd13;
        image[4] = 8'h22;  image[5] = 8'h33;  image[6] = 8'h44; image[7] = 8'd99;
        for (int k = 0; k < 8; k++) mem[k] = 8'h00;
        rd_q = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.arr_en) begin
            for (int k = 0; k < 8; k++) mem[k] <= image[k];
        end else begin
            if (bus.arr_wr_en) mem[bus.arr_wr_idx] <= bus.arr_wr_data;
            if (bus.arr_rd_en) rd_q <= mem[bus.arr_rd_idx];
        end
    end
    assign bus.arr_rd_data = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_idx = 3'd0; bus.a_wdata = 8'h00;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_idx = 3'd0; bus.b_wdata = 8'h00;

        // Reset held: everything quiet.
        sample();
        chk("rst_arr_en", 32'(bus.arr_en), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);

        // Release with A already requesting: INIT pulse, no grant.
        tick();
        reset = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_idx = 3'd0;
        sample();
        chk("init_arr_en", 32'(bus.arr_en), 1);
        chk("init_ready", 32'(bus.ready), 0);
        chk("init_a_gnt", 32'(bus.a_gnt), 0);

        // First RUN cycle: held request served.
        tick();
        sample();
        chk("run_arr_en", 32'(bus.arr_en), 0);
        chk("run_ready", 32'(bus.ready), 1);
        chk("rd0_a_gnt", 32'(bus.a_gnt), 1);
        chk("rd0_arr_rd_en", 32'(bus.arr_rd_en), 1);
        chk("rd0_arr_rd_idx", 32'(bus.arr_rd_idx), 0);
        chk("rd0_arr_wr_en", 32'(bus.arr_wr_en), 0);

        tick();
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_idx = 3'd1;
        sample();
        chk("rd0_a_rvalid", 32'(bus.a_rvalid), 1);
        chk("rd0_a_rdata", 32'(bus.a_rdata), 236);
        chk("rd0_b_rvalid", 32'(bus.b_rvalid), 0);
        chk("rdb_b_gnt", 32'(bus.b_gnt), 1);

        // B's result returns while A and B raise a tie (rr_last is B, so A wins).
        tick();
        bus.a_req = 1'b1; bus.a_idx = 3'd7;
        bus.b_req = 1'b1; bus.b_idx = 3'd1;
        sample();
        chk("rdb_b_rvalid", 32'(bus.b_rvalid), 1);
        chk("rdb_b_rdata", 32'(bus.b_rdata), 175);
        chk("rdb_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("tie_a_gnt", 32'(bus.a_gnt), 1);
        chk("tie_b_gnt", 32'(bus.b_gnt), 0);

        tick();
        bus.a_req = 1'b0;
        sample();
        chk("tie_b_gnt2", 32'(bus.b_gnt), 1);
        chk("tie_a_rvalid", 32'(bus.a_rvalid), 1);
        chk("tie_a_rdata", 32'(bus.a_rdata), 99);
        chk("tie_b_rvalid", 32'(bus.b_rvalid), 0);

        // Both hold requests for 6 cycles: strict alternation starting with A.
        tick();
        bus.a_req = 1'b1; bus.a_idx = 3'd0;
        bus.b_req = 1'b1; bus.b_idx = 3'd7;
        sample();
        chk("tie_b_rdata", 32'(bus.b_rdata), 175);
        chk("tie_b_rvalid2", 32'(bus.b_rvalid), 1);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin
                tick();
                sample();
            end
            chk("alt_a_gnt", 32'(bus.a_gnt), 32'((i % 2) == 0));
            chk("alt_b_gnt", 32'(bus.b_gnt), 32'((i % 2) == 1));
            chk("alt_both", 32'(bus.a_gnt & bus.b_gnt), 0);
            if (i != 0) begin
                chk("alt_a_rvalid", 32'(bus.a_rvalid), 32'((i % 2) == 1));
                chk("alt_b_rvalid", 32'(bus.b_rvalid), 32'((i % 2) == 0));
                chk("alt_rdata", 32'(bus.a_rdata | bus.b_rdata), ((i % 2) == 1) ? 236 : 99);
            end
        end

        // B writes idx3, A reads it back the next cycle.
        tick();
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_idx = 3'd3; bus.b_wdata = 8'h5A;
        sample();
        chk("alt_last_b_rvalid", 32'(bus.b_rvalid), 1);
        chk("alt_last_b_rdata", 32'(bus.b_rdata), 99);
        chk("wr_b_gnt", 32'(bus.b_gnt), 1);
        chk("wr_arr_wr_en", 32'(bus.arr_wr_en), 1);
        chk("wr_arr_wr_idx", 32'(bus.arr_wr_idx), 3);
        chk("wr_arr_wr_data", 32'(bus.arr_wr_data), 32'h5A);
        chk("wr_arr_rd_en", 32'(bus.arr_rd_en), 0);

        tick();
        bus.b_req = 1'b0; bus.b_we = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_idx = 3'd3;
        sample();
        chk("wr_b_rvalid", 32'(bus.b_rvalid), 0);
        chk("raw_a_gnt", 32'(bus.a_gnt), 1);

        tick();
        bus.a_req = 1'b0;
        sample();
        chk("raw_a_rvalid", 32'(bus.a_rvalid), 1);
        chk("raw_a_rdata", 32'(bus.a_rdata), 32'h5A);

        // Reset while A's read is pending.
        tick();
        bus.a_req = 1'b1; bus.a_idx = 3'd3;
        sample();
        chk("pend_a_gnt", 32'(bus.a_gnt), 1);

        tick();
        bus.a_req = 1'b0;
        reset = 1'b1;
        sample();
        chk("mid_rst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("mid_rst_a_rdata", 32'(bus.a_rdata), 0);
        chk("mid_rst_ready", 32'(bus.ready), 0);
        chk("mid_rst_arr_en", 32'(bus.arr_en), 0);

        tick();
        reset = 1'b0;
        sample();
        chk("reinit_arr_en", 32'(bus.arr_en), 1);
        chk("reinit_ready", 32'(bus.ready), 0);
        chk("reinit_a_rvalid", 32'(bus.a_rvalid), 0);

        tick();
        bus.a_req = 1'b1; bus.a_idx = 3'd3;
        sample();
        chk("rerun_arr_en", 32'(bus.arr_en), 0);
        chk("rerun_ready", 32'(bus.ready), 1);
        chk("rerun_a_gnt", 32'(bus.a_gnt), 1);

        tick();
        bus.a_req = 1'b0;
        sample();
        chk("restore_a_rvalid", 32'(bus.a_rvalid), 1);
        chk("restore_a_rdata", 32'(bus.a_rdata), 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
